reg_file_slave: RTL and testbench

- General-purpose register file for the MIPS core: 32 x 32-bit registers.
- Acts as the slave end of the register-read bus; the decode stage is the master.
- Also takes one write-back port from the WB stage.
- Provides two combinational read ports with same-cycle write-to-read bypass, and a synchronous write port; register 0 is hardwired to zero.

---
 rtl/reg_file_slave_if.sv | 30 +++
 rtl/reg_file_slave.sv | 79 +++++++
 tb/tb_reg_file_slave.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/reg_file_slave_if.sv
// Register-read bus between the decode stage (master) and the register file (slave).
// Each read request is a {en, addr} pair; the slave answers combinationally on rN_data.
interface i_regbus #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
   } reg_info_t;

   reg_info_t         r1_info;
   reg_info_t         r2_info;
   logic [DATA_W-1:0] r1_data;
   logic [DATA_W-1:0] r2_data;

   modport slave (
      input  r1_info,
      input  r2_info,
      output r1_data,
      output r2_data
   );

   modport master (
      output r1_info,
      output r2_info,
      input  r1_data,
      input  r2_data
   );
endinterface

// File: rtl/reg_file_slave.sv
// MIPS general-purpose register file: two combinational read ports with write-back
// bypass, one synchronous write port, register 0 hardwired to zero.
module reg_file_slave #(
   parameter int NUM_REGS       = 32,
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   i_regbus.slave            regbus,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
      $error("reg_file_slave: NUM_REGS must equal 2**ADDR_W");
   end

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] r1_data;
   logic [DATA_W-1:0] r2_data;

   // Read priority: reset, disabled port, r0, same-cycle write-back, storage.
   function automatic logic [DATA_W-1:0] rd_port(
      input logic              rst_n_v,
      input logic              en,
      input logic [ADDR_W-1:0] addr,
      input logic              wb_en_v,
      input logic [ADDR_W-1:0] wb_addr_v,
      input logic [DATA_W-1:0] wb_data_v,
      input logic [DATA_W-1:0] stored
   );
      logic [DATA_W-1:0] res;
      res = '0;
      if (rst_n_v && en && (addr != '0)) begin
         if (wb_en_v && (wb_addr_v == addr)) begin
            res = wb_data_v;
         end else begin
            res = stored;
         end
      end
      return res;
   endfunction

   always_comb begin
      regs_d = regs_q;
      if (wb_en && (wb_addr != '0)) begin
         regs_d[wb_addr] = wb_data;
      end
      regs_d[0] = '0;
   end

   // Reset takes precedence over a coincident write-back.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (CLEAR_ON_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               regs_q[i] <= '0;
            end
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      r1_data = rd_port(rst_n, regbus.r1_info.en, regbus.r1_info.addr,
                        wb_en, wb_addr, wb_data, regs_q[regbus.r1_info.addr]);
      r2_data = rd_port(rst_n, regbus.r2_info.en, regbus.r2_info.addr,
                        wb_en, wb_addr, wb_data, regs_q[regbus.r2_info.addr]);
   end

   assign regbus.r1_data = r1_data;
   assign regbus.r2_data = r2_data;

endmodule

// File: tb/tb_reg_file_slave.sv
// Directed bench for reg_file_slave: vector table plus a full-register sweep.
module tb_reg_file_slave;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              rst_n;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   i_regbus #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   reg_file_slave #(
      .NUM_REGS(32), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .regbus(bus),
      .wb_en(wb_en),
      .wb_addr(wb_addr),
      .wb_data(wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              rst_n;
      logic              wb_en;
      logic [ADDR_W-1:0] wb_addr;
      logic [DATA_W-1:0] wb_data;
      logic              r1_en;
      logic [ADDR_W-1:0] r1_addr;
      logic              r2_en;
      logic [ADDR_W-1:0] r2_addr;
      logic [DATA_W-1:0] exp1;
      logic [DATA_W-1:0] exp2;
   } vec_t;

   vec_t vecs[$];
   int   n_tests;
   int   n_fail;

   function automatic vec_t mk(input logic rs, input logic we, input int wa, input logic [31:0] wd,
                               input logic e1, input int a1, input logic e2, input int a2,
                               input logic [31:0] x1, input logic [31:0] x2);
      vec_t v;
      v.rst_n = rs;  v.wb_en = we;  v.wb_addr = ADDR_W'(wa);  v.wb_data = wd;
      v.r1_en = e1;  v.r1_addr = ADDR_W'(a1);
      v.r2_en = e2;  v.r2_addr = ADDR_W'(a2);
      v.exp1 = x1;   v.exp2 = x2;
      return v;
   endfunction

   task automatic drive(input logic rs, input logic we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd, input logic e1, input logic [ADDR_W-1:0] a1,
                        input logic e2, input logic [ADDR_W-1:0] a2);
      @(negedge clk);
      rst_n   = rs;
      wb_en   = we;
      wb_addr = wa;
      wb_data = wd;
      bus.r1_info = {e1, a1};
      bus.r2_info = {e2, a2};
      #1;
   endtask

   task automatic check(input string name, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wb_en = 1'b0;
      wb_addr = '0;
      wb_data = '0;
      bus.r1_info = '0;
      bus.r2_info = '0;
      n_tests = 0;
      n_fail = 0;

      //        rst we wa  wd            e1 a1 e2 a2  exp1          exp2
      vecs.push_back(mk(0, 0, 0,  32'h0,        1, 5, 1, 0,  32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 5,  32'hDEADBEEF, 1, 5, 0, 5,  32'hDEADBEEF, 32'h0));
      vecs.push_back(mk(1, 0, 0,  32'h0,        1, 5, 1, 5,  32'hDEADBEEF, 32'hDEADBEEF));
      vecs.push_back(mk(0, 0, 0,  32'h0,        1, 5, 1, 5,  32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 0,  32'h0,        1, 5, 1, 0,  32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 7,  32'h12345678, 1, 6, 0, 7,  32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 0,  32'h0,        1, 7, 1, 7,  32'h12345678, 32'h12345678));
      vecs.push_back(mk(1, 0, 0,  32'h0,        1, 7, 0, 7,  32'h12345678, 32'h0));
      vecs.push_back(mk(1, 1, 0,  32'hFFFFFFFF, 1, 0, 1, 0,  32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 0,  32'h0,        1, 0, 1, 0,  32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 9,  32'h1,        0, 9, 1, 9,  32'h0,        32'h1));
      vecs.push_back(mk(1, 1, 10, 32'hCAFE,     1, 9, 1, 10, 32'h1,        32'hCAFE));
      vecs.push_back(mk(1, 1, 9,  32'hAAAA5555, 1, 9, 1, 10, 32'hAAAA5555, 32'hCAFE));
      vecs.push_back(mk(1, 0, 0,  32'h0,        1, 9, 1, 9,  32'hAAAA5555, 32'hAAAA5555));
      vecs.push_back(mk(1, 1, 11, 32'h77,       1, 11, 1, 11, 32'h77,      32'h77));
      vecs.push_back(mk(1, 1, 3,  32'h99,       1, 3, 1, 11, 32'h99,       32'h77));
      vecs.push_back(mk(0, 1, 3,  32'h55,       1, 3, 1, 3,  32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 0,  32'h0,        1, 3, 1, 9,  32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 4,  32'h1234,     1, 4, 1, 11, 32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 0,  32'h0,        1, 4, 1, 7,  32'h0,        32'h0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data,
               vecs[i].r1_en, vecs[i].r1_addr, vecs[i].r2_en, vecs[i].r2_addr);
         check($sformatf("vec%0d.r1", i), bus.r1_data, vecs[i].exp1);
         check($sformatf("vec%0d.r2", i), bus.r2_data, vecs[i].exp2);
      end

      // Sweep: fill every register with index*0x01010101, then read mirrored pairs.
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i * 32'h01010101), 1'b0, '0, 1'b0, '0);
      end
      for (int i = 0; i < 32; i++) begin
         logic [DATA_W-1:0] e1;
         logic [DATA_W-1:0] e2;
         e1 = DATA_W'(i * 32'h01010101);
         e2 = DATA_W'((31 - i) * 32'h01010101);
         drive(1'b1, 1'b0, '0, '0, 1'b1, ADDR_W'(i), 1'b1, ADDR_W'(31 - i));
         check($sformatf("sweep%0d.r1", i), bus.r1_data, e1);
         check($sformatf("sweep%0d.r2", i), bus.r2_data, e2);
      end

      // Reset with CLEAR_ON_RESET wipes the swept contents.
      drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd31, 1'b1, 5'd1);
      drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd31, 1'b1, 5'd1);
      check("post_reset.r31", bus.r1_data, 32'h0);
      check("post_reset.r1", bus.r2_data, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
